// File: rtl/lcd_fb_arbiter_if.sv
// lcd_fb_arbiter_if
//  Bundles the two frame-buffer writer handshakes and the single-port RAM bus.
//  slave  : the arbiter side (takes writer requests, drives the RAM port)
//  master : the environment side (writers issue requests, RAM returns read data)
//  Writer  : wrN_req / wrN_addr / wrN_data in, wrN_ack out (accept = req & ack at edge)
//  RAM     : ram_en / ram_we / ram_addr / ram_wdata out, ram_rdata in (1-cycle read latency)
interface lcd_fb_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              wr0_req;
  logic [ADDR_W-1:0] wr0_addr;
  logic [15:0]       wr0_data;
  logic              wr0_ack;
  logic              wr1_req;
  logic [ADDR_W-1:0] wr1_addr;
  logic [15:0]       wr1_data;
  logic              wr1_ack;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;

  modport master (
    output wr0_req, wr0_addr, wr0_data, input wr0_ack,
    output wr1_req, wr1_addr, wr1_data, input wr1_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

  modport slave (
    input  wr0_req, wr0_addr, wr0_data, output wr0_ack,
    input  wr1_req, wr1_addr, wr1_data, output wr1_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
endinterface

// File: rtl/lcd_fb_arbiter.sv
// lcd_fb_arbiter
//  Owns the single-port RGB565 frame-buffer RAM behind the LCD timing driver.
//  Display scan reads always win; the two writers (0 = plotter, 1 = overlay) share
//  the remaining cycles round-robin with a burst cap. Read data is expanded to RGB888.
// Ports
//  lcd_pclk, rst_n : pixel clock, async active-low reset
//  frame_start     : vsync level, holds the scan address at 0
//  rd_req          : scan data request; pixel_data valid the following cycle
//  pixel_data      : RGB888 expansion of ram_rdata (combinational)
//  drop_cnt        : saturating count of writes dropped for address >= FB_DEPTH
//  bus             : writer handshakes + RAM port (lcd_fb_arbiter_if.slave)
module lcd_fb_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int FB_DEPTH  = 384000,
  parameter int MAX_BURST = 16
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              rd_req,
  output logic [23:0]       pixel_data,
  output logic [7:0]        drop_cnt,
  lcd_fb_arbiter_if.slave   bus
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} st_t;

  st_t               state, state_nxt;
  logic              rr_ptr, rr_nxt;
  logic [BW-1:0]     burst_cnt, burst_nxt;
  logic [ADDR_W-1:0] rd_addr;

  // Writers viewed as a 2-entry array so the granted one is picked by index.
  logic [1:0]             req;
  logic [1:0][ADDR_W-1:0] waddr;
  logic [1:0][15:0]       wdata;
  logic                   gidx, oidx, accept, in_range, burst_end;

  assign req   = {bus.wr1_req,  bus.wr0_req};
  assign waddr = {bus.wr1_addr, bus.wr0_addr};
  assign wdata = {bus.wr1_data, bus.wr0_data};

  assign gidx      = (state == GNT1);
  assign oidx      = ~gidx;
  assign accept    = (state != IDLE) & req[gidx] & ~rd_req;
  assign in_range  = 32'(waddr[gidx]) < 32'(FB_DEPTH);
  // This accept brings the burst count up to the cap.
  assign burst_end = (burst_cnt == BW'(MAX_BURST - 1));

  // State register
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Next state. A read stall freezes grant, pointer and burst count.
  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    burst_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (req[0] & req[1]) state_nxt = rr_ptr ? GNT1 : GNT0;
        else if (req[0])     state_nxt = GNT0;
        else if (req[1])     state_nxt = GNT1;
      end
      GNT0, GNT1: begin
        if (!rd_req) begin
          if (req[gidx]) begin
            if (burst_end) begin
              burst_nxt = '0;
              if (req[oidx]) begin
                state_nxt = oidx ? GNT1 : GNT0;
                rr_nxt    = oidx;
              end
            end else begin
              burst_nxt = burst_cnt + 1'b1;
            end
          end else begin
            burst_nxt = '0;
            rr_nxt    = oidx;
            state_nxt = req[oidx] ? (oidx ? GNT1 : GNT0) : IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Reads own the port; an out-of-range write is acked but never reaches RAM.
  always_comb begin
    bus.wr0_ack   = (state == GNT0) & req[0] & ~rd_req;
    bus.wr1_ack   = (state == GNT1) & req[1] & ~rd_req;
    bus.ram_en    = rd_req;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = rd_addr;
    bus.ram_wdata = wdata[gidx];
    if (accept & in_range) begin
      bus.ram_en   = 1'b1;
      bus.ram_we   = 1'b1;
      bus.ram_addr = waddr[gidx];
    end
  end

  // Scan address and drop counter
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr  <= '0;
      drop_cnt <= '0;
    end else begin
      if (frame_start)  rd_addr <= '0;
      else if (rd_req)  rd_addr <= rd_addr + 1'b1;
      if (accept & ~in_range & (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // RGB565 -> RGB888 by replicating each channel's MSBs into the new LSBs.
  assign pixel_data = {bus.ram_rdata[15:11], bus.ram_rdata[15:13],
                       bus.ram_rdata[10:5],  bus.ram_rdata[10:9],
                       bus.ram_rdata[4:0],   bus.ram_rdata[4:2]};

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
module tb_lcd_fb_arbiter;
  localparam int AW    = 19;
  localparam int DEPTH = 384000;
  localparam int MB    = 16;
  localparam int MSZ   = 1 << AW;

  logic        lcd_pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        rd_req = 1'b0;
  logic [23:0] pixel_data;
  logic [7:0]  drop_cnt;

  lcd_fb_arbiter_if #(.ADDR_W(AW)) bus();

  lcd_fb_arbiter #(.ADDR_W(AW), .FB_DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .frame_start(frame_start), .rd_req(rd_req),
    .pixel_data(pixel_data), .drop_cnt(drop_cnt), .bus(bus)
  );

  always #5 lcd_pclk = ~lcd_pclk;

  // RAM seen by the DUT, plus the bench's own view of what it should hold
  logic [15:0] mem    [MSZ];
  logic [15:0] shadow [MSZ];
  always @(posedge lcd_pclk)
    if (bus.ram_en) begin
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end

  int vectors = 0, miscompares = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: owner of the write slot (-1 none), preferred writer, accepts in run
  int m_gnt, m_pref, m_run, m_drop, m_rd, m_pix_addr;
  bit m_pix_vld;
  logic [23:0] m_pix;
  bit t2_on = 0;

  // Writers: pending request, mode 0 one-shot, 1 continuous, 2 random refill
  bit          pend [2];
  int          wa   [2];
  logic [15:0] wd   [2];
  int          mode = 0;
  int          log_q[$];
  int          exp_rd = -1;

  function automatic logic [23:0] rgb(logic [15:0] d);
    int r, g, b;
    r = int'(d[15:11]); g = int'(d[10:5]); b = int'(d[4:0]);
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  function automatic int rand_addr();
    int k;
    k = int'($urandom_range(0, 15));
    if (k == 0) return DEPTH + int'($urandom_range(0, 1000));
    if (k == 1) return DEPTH - 1;
    return int'($urandom_range(0, 127));
  endfunction

  task automatic drive_wr();
    bus.wr0_req = pend[0]; bus.wr0_addr = AW'(wa[0]); bus.wr0_data = wd[0];
    bus.wr1_req = pend[1]; bus.wr1_addr = AW'(wa[1]); bus.wr1_data = wd[1];
  endtask

  task automatic cyc();
    bit ea [2];
    int g, o;
    if (mode == 2)
      for (int w = 0; w < 2; w++)
        if (!pend[w] && $urandom_range(0, 2) == 0) begin
          pend[w] = 1; wa[w] = rand_addr(); wd[w] = 16'($urandom);
        end
    drive_wr();
    for (int w = 0; w < 2; w++) ea[w] = (m_gnt == w) && pend[w] && !rd_req;
    g = ea[0] ? 0 : (ea[1] ? 1 : -1);
    @(negedge lcd_pclk);
    chk("ack0", bus.wr0_ack, ea[0]);
    chk("ack1", bus.wr1_ack, ea[1]);
    chk("both_ack", bus.wr0_ack & bus.wr1_ack, 0);
    if (rd_req) begin
      chk("rd_en", bus.ram_en, 1);
      chk("rd_we", bus.ram_we, 0);
      chk("rd_addr", bus.ram_addr, m_rd);
      if (exp_rd >= 0) chk("t2_addr", bus.ram_addr, exp_rd);
    end else if (g >= 0 && wa[g] < DEPTH) begin
      chk("wr_en", bus.ram_en, 1);
      chk("wr_we", bus.ram_we, 1);
      chk("wr_addr", bus.ram_addr, wa[g]);
      chk("wr_data", bus.ram_wdata, wd[g]);
    end else begin
      chk("idle_en", bus.ram_en, 0);
      chk("idle_we", bus.ram_we, 0);
    end
    chk("drop", drop_cnt, m_drop);
    if (m_pix_vld) begin
      chk("pixel", pixel_data, m_pix);
      if (t2_on && m_pix_addr == 5) chk("t2_f800", pixel_data, 24'hFF0000);
    end
    log_q.push_back(g);
    @(posedge lcd_pclk);
    m_pix_vld = rd_req;
    if (rd_req) begin m_pix = rgb(shadow[m_rd]); m_pix_addr = m_rd; end
    if (frame_start) m_rd = 0;
    else if (rd_req) m_rd = (m_rd + 1) % MSZ;
    if (m_gnt < 0) begin
      if (pend[0] && pend[1]) m_gnt = m_pref;
      else if (pend[0])       m_gnt = 0;
      else if (pend[1])       m_gnt = 1;
    end else if (!rd_req) begin
      o = 1 - m_gnt;
      if (pend[m_gnt]) begin
        m_run++;
        if (m_run == MB) begin
          m_run = 0;
          if (pend[o]) begin m_gnt = o; m_pref = o; end
        end
      end else begin
        m_run = 0; m_pref = o; m_gnt = pend[o] ? o : -1;
      end
    end
    if (g >= 0) begin
      if (wa[g] >= DEPTH) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
      else shadow[wa[g]] = wd[g];
      if (mode == 1) begin
        if (wa[g] < DEPTH) wa[g] = wa[g] + 1;
        wd[g] = 16'($urandom);
      end else pend[g] = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; frame_start = 1'b0; rd_req = 1'b0;
    drive_wr();
    #1;
    chk("rst_ack0", bus.wr0_ack, 0);
    chk("rst_ack1", bus.wr1_ack, 0);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_drop", drop_cnt, 0);
    rd_req = 1'b1;
    #1;
    chk("rst_rdaddr", bus.ram_addr, 0);
    chk("rst_rden", bus.ram_en, 1);
    rd_req = 1'b0;
    @(posedge lcd_pclk); @(posedge lcd_pclk); #1;
    rst_n = 1'b1;
    m_gnt = -1; m_pref = 0; m_run = 0; m_drop = 0; m_rd = 0; m_pix_vld = 0;
  endtask

  initial begin
    int k;
    for (int i = 0; i < MSZ; i++) begin mem[i] = 16'(i); shadow[i] = 16'(i); end
    mem[5] = 16'hF800; shadow[5] = 16'hF800;

    // T1: reset with both writers requesting, then let those writes drain
    pend = '{1, 1}; wa = '{100, 200}; wd = '{16'h1234, 16'hBEEF};
    do_reset();
    repeat (6) cyc();

    // T2: frame_start, then 800 scan reads
    frame_start = 1'b1; repeat (2) cyc(); frame_start = 1'b0;
    t2_on = 1;
    for (int i = 0; i < 800; i++) begin rd_req = 1'b1; exp_rd = i; cyc(); end
    rd_req = 1'b0; exp_rd = -1; cyc(); t2_on = 0;

    // T3: write held off by scan reads
    log_q.delete();
    pend[0] = 1; wa[0] = 10; wd[0] = 16'h0A0A; mode = 0;
    rd_req = 1'b1; repeat (5) cyc();
    rd_req = 1'b0; repeat (3) cyc();
    for (int i = 0; i < 5; i++) chk("t3_stall", log_q[i], -1);
    chk("t3_first", log_q[5], 0);

    // T4a: both writers continuous, no reads
    do_reset();
    log_q.delete();
    pend = '{1, 1}; wa = '{1000, 2000}; mode = 1;
    repeat (70) cyc();
    chk("t4_bubble", log_q[0], -1);
    for (int i = 1; i < 70; i++) chk("t4_rr", log_q[i], ((i - 1) / 16) % 2);

    // T4b: reset mid-burst, then round-robin with random read stalls
    do_reset();
    log_q.delete();
    repeat (300) begin rd_req = ($urandom_range(0, 3) == 0); cyc(); end
    rd_req = 1'b0;
    k = 0;
    foreach (log_q[i]) if (log_q[i] >= 0) begin chk("t4_stall_rr", log_q[i], (k / 16) % 2); k++; end

    // T5: lone writer 1 runs past the burst cap without a bubble
    pend = '{0, 0}; repeat (3) cyc();
    log_q.delete();
    pend[1] = 1; wa[1] = 3000; mode = 1;
    repeat (41) cyc();
    pend[1] = 0; cyc();
    chk("t5_bubble", log_q[0], -1);
    for (int i = 1; i <= 40; i++) chk("t5_lone", log_q[i], 1);

    // T6: out-of-range writes are acked, dropped and counted to saturation
    pend = '{0, 0};
    do_reset();
    pend[0] = 1; wa[0] = DEPTH; mode = 1;
    cyc(); cyc();
    chk("t6_one", drop_cnt, 1);
    repeat (300) cyc();
    chk("t6_sat", drop_cnt, 255);
    pend[0] = 0; cyc();

    // Random mix of scan reads, frame starts and writer traffic
    do_reset();
    mode = 2;
    for (int n = 0; n < 3000; n++) begin
      frame_start = (n % 150 == 0);
      rd_req = !frame_start && ($urandom_range(0, 2) == 0);
      cyc();
    end
    frame_start = 1'b0; rd_req = 1'b0; mode = 0; pend = '{0, 0};
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
